// File: rtl/step_pkg.sv
// Shared state encoding and timing constants for the step/dir pulse generator.
package step_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIR_SETUP,
        PULSE_HIGH,
        PULSE_LOW,
        DONE
    } step_state_t;

    localparam int MIN_LOW_CYCLES = 2;
    localparam int DIR_SAMPLE_LAG = 2;

endpackage

// File: rtl/step_cycle_timer.sv
// Loadable down-counter: load N-1 to time an N-cycle phase; o_expired is high in its last cycle.
module step_cycle_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/step_dir_generator.sv
// Step/dir transmitter: turns accepted moves into step pulses with guaranteed setup, high and low times.
// Define STEP_POSITION_EN to add a signed position counter with a synchronous clear.
module step_dir_generator
    import step_pkg::*;
#(
    parameter int COUNT_W          = 32,
    parameter int INTERVAL_W       = 16,
    parameter int PULSE_CYCLES     = 4,
    parameter int DIR_SETUP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [COUNT_W-1:0]    cmd_steps,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic                  abort,
    output logic                  step,
    output logic                  dir,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [COUNT_W-1:0]    steps_done,
`ifdef STEP_POSITION_EN
    input  logic                  position_clear,
    output logic signed [COUNT_W:0] position,
`endif
    output step_state_t           state
);

    // Setup must outlast the downstream dir sampling lag, whatever the parameter says.
    localparam int SETUP_CYCLES = (DIR_SETUP_CYCLES > DIR_SAMPLE_LAG) ? DIR_SETUP_CYCLES
                                                                      : DIR_SAMPLE_LAG + 1;
    localparam logic [INTERVAL_W:0]   MIN_PERIOD_EXT = (INTERVAL_W+1)'(PULSE_CYCLES + MIN_LOW_CYCLES);
    localparam logic [INTERVAL_W-1:0] SETUP_LD = INTERVAL_W'(SETUP_CYCLES - 1);
    localparam logic [INTERVAL_W-1:0] PULSE_LD = INTERVAL_W'(PULSE_CYCLES - 1);
    localparam logic [INTERVAL_W-1:0] TAIL_LD  = INTERVAL_W'(MIN_LOW_CYCLES - 1);
    localparam logic [INTERVAL_W-1:0] LOW_ADJ  = INTERVAL_W'(PULSE_CYCLES + 1);

    step_state_t           r_state, w_next;
    logic                  r_step, r_dir, r_busy, r_done, r_aborted, r_cmd_ready;
    logic                  r_abort_req, r_abort_tail;
    logic [COUNT_W-1:0]    r_remaining, r_steps_done;
    logic [INTERVAL_W-1:0] r_eff_int, w_eff_int, w_load_val;
    logic [INTERVAL_W:0]   w_eff_ext;
    logic                  w_accept, w_load, w_expired, w_state_busy, w_next_busy;
    logic                  w_abort_pend, w_step_entry;

    step_cycle_timer #(.W(INTERVAL_W)) u_timer (
        .i_clk      (clk),
        .i_rst_n    (resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    assign w_accept     = cmd_valid & r_cmd_ready;
    assign w_state_busy = (r_state == DIR_SETUP) || (r_state == PULSE_HIGH) || (r_state == PULSE_LOW);
    assign w_next_busy  = (w_next == DIR_SETUP) || (w_next == PULSE_HIGH) || (w_next == PULSE_LOW);
    assign w_abort_pend = w_state_busy & (r_abort_req | abort);
    assign w_step_entry = (w_next == PULSE_HIGH) && (r_state != PULSE_HIGH);
    assign w_eff_ext    = ({1'b0, cmd_interval} > MIN_PERIOD_EXT) ? {1'b0, cmd_interval} : MIN_PERIOD_EXT;
    assign w_eff_int    = w_eff_ext[INTERVAL_W] ? '1 : w_eff_ext[INTERVAL_W-1:0];

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_steps == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next     = DIR_SETUP;
                        w_load     = 1'b1;
                        w_load_val = SETUP_LD;
                    end
                end
            end
            DIR_SETUP: begin
                if (w_abort_pend) begin
                    w_next = DONE;
                end else if (w_expired) begin
                    w_next     = PULSE_HIGH;
                    w_load     = 1'b1;
                    w_load_val = PULSE_LD;
                end
            end
            PULSE_HIGH: begin
                // An abort never truncates a pulse; it only shortens the following low phase.
                if (w_expired) begin
                    w_next     = PULSE_LOW;
                    w_load     = 1'b1;
                    w_load_val = w_abort_pend ? TAIL_LD : (r_eff_int - LOW_ADJ);
                end
            end
            PULSE_LOW: begin
                if (w_abort_pend && !r_abort_tail) begin
                    w_next = DONE;
                end else if (w_expired) begin
                    if (r_abort_tail || (r_remaining == '0)) begin
                        w_next = DONE;
                    end else begin
                        w_next     = PULSE_HIGH;
                        w_load     = 1'b1;
                        w_load_val = PULSE_LD;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_abort_req  <= 1'b0;
            r_abort_tail <= 1'b0;
            r_remaining  <= '0;
            r_steps_done <= '0;
            r_eff_int    <= '0;
        end else begin
            r_step       <= (w_next == PULSE_HIGH);
            r_busy       <= w_next_busy;
            r_done       <= (w_next == DONE);
            r_cmd_ready  <= (w_next == IDLE);
            r_abort_req  <= w_next_busy & w_abort_pend;
            r_abort_tail <= (w_next == PULSE_LOW) &
                            ((r_state == PULSE_HIGH) ? w_abort_pend : r_abort_tail);
            if (w_accept) begin
                r_dir        <= cmd_dir;
                r_remaining  <= cmd_steps;
                r_eff_int    <= w_eff_int;
                r_steps_done <= '0;
                r_aborted    <= 1'b0;
            end else if (w_step_entry) begin
                r_steps_done <= r_steps_done + 1'b1;
                r_remaining  <= r_remaining - 1'b1;
            end
            if ((w_next == DONE) && w_abort_pend) begin
                r_aborted <= 1'b1;
            end
        end
    end

`ifdef STEP_POSITION_EN
    localparam logic signed [COUNT_W:0] POS_ONE = 1;
    logic signed [COUNT_W:0] r_position;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_position <= '0;
        end else if (position_clear) begin
            r_position <= '0;
        end else if (w_step_entry) begin
            r_position <= r_dir ? (r_position + POS_ONE) : (r_position - POS_ONE);
        end
    end

    assign position = r_position;
`endif

    assign step       = r_step;
    assign dir        = r_dir;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign cmd_ready  = r_cmd_ready;
    assign steps_done = r_steps_done;
    assign state      = r_state;

endmodule
